md_unit_ctrl: RTL and testbench

Sequencing controller for the multiply/divide unit and its HI/LO register pair in the pipelined MIPS core. It accepts a start pulse from the E stage and holds the unit busy for a fixed multi-cycle latency per operation. It commits the results to HI/LO when the latency expires and raises a stall request, so the D stage cannot issue another HI/LO-touching instruction while the unit is occupied. `mthi`/`mtlo` writes are also arbitrated here.

---
 rtl/md_unit_ctrl.sv | 88 ++++++++
 tb/tb_md_unit_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO pair and the D-stage stall request
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t      state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic [31:0] pHi, pLo, pHiNext, pLoNext, hiNext, loNext;
    logic        isArith, isSigned;
    logic [63:0] prodS, prodU, result;
    logic [31:0] aMag, bMag, quoMag, remMag, quoRes, remRes;

    assign isArith  = start & ~op[2];
    assign isSigned = (op == 3'd2);
    assign prodS    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prodU    = {32'd0, a} * {32'd0, b};
    // Signed divide works on magnitudes; 8000_0000 / -1 wraps back to 8000_0000 naturally
    assign aMag     = (isSigned & a[31]) ? 32'(-a) : a;
    assign bMag     = (isSigned & b[31]) ? 32'(-b) : b;
    assign quoMag   = (b == 32'd0) ? 32'd0 : aMag / bMag;
    assign remMag   = (b == 32'd0) ? 32'd0 : aMag % bMag;
    assign quoRes   = (b == 32'd0) ? 32'hFFFF_FFFF : ((isSigned & (a[31] ^ b[31])) ? 32'(-quoMag) : quoMag);
    assign remRes   = (b == 32'd0) ? a : ((isSigned & a[31]) ? 32'(-remMag) : remMag);
    assign result   = op[1] ? {remRes, quoRes} : (op[0] ? prodU : prodS);

    assign busy      = (cnt != 4'd0);
    assign stall_req = md_use_d & (busy | isArith);

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        hiNext    = hi;
        loNext    = lo;
        pHiNext   = pHi;
        pLoNext   = pLo;
        if (state == RUN) begin
            cntNext = cnt - 4'd1;
            if (cnt == 4'd1) begin
                stateNext = IDLE;
                hiNext    = pHi;
                loNext    = pLo;
            end
        end else if (start) begin
            if (isArith) begin
                stateNext          = RUN;
                cntNext            = op[1] ? DIV_N : MULT_N;
                {pHiNext, pLoNext} = result;
            end
            hiNext = (op == 3'd4) ? a : hi;
            loNext = (op == 3'd5) ? a : lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            pHi   <= 32'd0;
            pLo   <= 32'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            hi    <= hiNext;
            lo    <= loNext;
            pHi   <= pHiNext;
            pLo   <= pLoNext;
        end
    end
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed and random checks of md_unit_ctrl against a cycle-count/arithmetic reference model
module tb_md_unit_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        md_use_d = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_use_d(md_use_d), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int          nCmp = 0;
    int          nErr = 0;
    int          mLeft = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    logic [63:0] mPend = 64'd0;

    function automatic logic [63:0] refCalc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        if (o == 3'd0) return 64'(sx * sy);
        if (o == 3'd1) return ux * uy;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 3'd2) return {32'(sx % sy), 32'(sx / sy)};
        return {32'(ux % uy), 32'(ux / uy)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkOuts();
        chk("busy", 32'(busy), 32'(mLeft > 0));
        chk("hi", hi, mHi);
        chk("lo", lo, mLo);
    endtask

    task automatic cyc(input logic s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic u);
        start = s;
        op = o;
        a = x;
        b = y;
        md_use_d = u;
        #1;
        chk("stall_req", 32'(stall_req), 32'(u && (mLeft > 0 || (s && o < 3'd4))));
        @(posedge clk);
        if (mLeft > 0) begin
            mLeft--;
            if (mLeft == 0) {mHi, mLo} = mPend;
        end else if (s && o < 3'd4) begin
            mPend = refCalc(o, x, y);
            mLeft = (o < 3'd2) ? 5 : 10;
        end else if (s && o == 3'd4) mHi = x;
        else if (s && o == 3'd5) mLo = x;
        #1;
        checkOuts();
    endtask

    task automatic doReset();
        reset = 1'b1;
        start = 1'b0;
        md_use_d = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mLeft = 0;
        mHi = 32'd0;
        mLo = 32'd0;
        chk("reset_stall", 32'(stall_req), 32'd0);
        checkOuts();
    endtask

    task automatic idle(input int n, input logic u);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0, u);
    endtask

    initial begin
        doReset();
        cyc(1'b1, 3'd4, 32'h1111_2222, 32'd0, 1'b0);
        cyc(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
        idle(6, 1'b1);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        cyc(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle(5, 1'b0);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        cyc(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        cyc(1'b1, 3'd4, 32'h0000_1234, 32'd0, 1'b1);
        cyc(1'b1, 3'd0, 32'd9, 32'd9, 1'b1);
        idle(7, 1'b1);
        chk("div_hold_hi", hi, 32'hFFFF_FFFE);
        idle(1, 1'b1);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        cyc(1'b1, 3'd0, 32'd6, 32'd7, 1'b1);
        idle(5, 1'b0);
        chk("b2b_lo", lo, 32'd42);
        cyc(1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
        idle(10, 1'b0);
        chk("divu0_hi", hi, 32'd7);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        cyc(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(10, 1'b0);
        chk("divovf_hi", hi, 32'd0);
        chk("divovf_lo", lo, 32'h8000_0000);
        cyc(1'b1, 3'd5, 32'hCAFE_F00D, 32'd0, 1'b1);
        chk("mtlo", lo, 32'hCAFE_F00D);
        cyc(1'b1, 3'd6, 32'h5555_5555, 32'd1, 1'b1);
        cyc(1'b1, 3'd7, 32'h6666_6666, 32'd1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] y;
            y = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom_range(0, 1) != 0 ? $urandom : $urandom_range(1, 20));
            cyc($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), $urandom, y, 1'($urandom_range(0, 1)));
        end
        idle(10, 1'b0);
        cyc(1'b1, 3'd2, 32'd1000, 32'd3, 1'b1);
        idle(3, 1'b1);
        doReset();
        idle(12, 1'b0);
        chk("post_reset_hi", hi, 32'd0);
        chk("post_reset_lo", lo, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
